// File: rtl/video_mnist_seg_vote.sv
// Sliding-window class vote over an AXI4-Stream video line.
// Each accepted pixel carries a one-hot classifier result. The block keeps a
// WINDOW-deep history per line and emits the majority class (ties go to the
// lowest index) together with its vote count. Sideband signals pass through.
module video_mnist_seg_vote #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TDATA_WIDTH   = 24,
  parameter int unsigned NUM_CLASS     = 10,
  parameter int unsigned TNUMBER_WIDTH = 4,
  parameter int unsigned TCOUNT_WIDTH  = 4,
  parameter int unsigned WINDOW        = 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic [NUM_CLASS-1:0]     s_axi4s_tclass,
  input  logic                     s_axi4s_tbinary,
  input  logic                     s_axi4s_tdetection,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,

  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tbinary,
  output logic                     m_axi4s_tdetection,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  logic                                    accept;
  logic                                    line_start;
  logic                                    new_vld;
  logic [TNUMBER_WIDTH-1:0]                new_cls;
  logic                                    old_vld;
  logic [TNUMBER_WIDTH-1:0]                old_cls;
  logic [WINDOW-1:0]                       base_vld;
  logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0]  base_cnt;
  logic [TNUMBER_WIDTH-1:0]                win_num;
  logic [TCOUNT_WIDTH-1:0]                 win_cnt;

  logic                                    line_start_q, line_start_d;
  logic [WINDOW-1:0]                       hist_vld_q, hist_vld_d;
  logic [WINDOW-1:0][TNUMBER_WIDTH-1:0]    hist_cls_q, hist_cls_d;
  logic [NUM_CLASS-1:0][TCOUNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [TUSER_WIDTH-1:0]                  m_tuser_q, m_tuser_d;
  logic                                    m_tlast_q, m_tlast_d;
  logic [TDATA_WIDTH-1:0]                  m_tdata_q, m_tdata_d;
  logic                                    m_tbinary_q, m_tbinary_d;
  logic                                    m_tdetection_q, m_tdetection_d;
  logic [TNUMBER_WIDTH-1:0]                m_tnumber_q, m_tnumber_d;
  logic [TCOUNT_WIDTH-1:0]                 m_tcount_q, m_tcount_d;
  logic                                    m_tvalid_q, m_tvalid_d;

  assign s_axi4s_tready = !m_tvalid_q || m_axi4s_tready;
  assign accept         = s_axi4s_tvalid && s_axi4s_tready;
  assign line_start     = line_start_q || s_axi4s_tuser[0];

  // Lowest set bit of the one-hot class vector; all-zero is a no-vote entry.
  always_comb begin
    new_vld = |s_axi4s_tclass;
    new_cls = '0;
    for (int unsigned i = NUM_CLASS; i > 0; i--) begin
      if (s_axi4s_tclass[i-1]) new_cls = TNUMBER_WIDTH'(i - 1);
    end
  end

  // History shift and incremental histogram update; a line start wipes the
  // window first so the vote never spans lines or frames.
  always_comb begin
    base_vld     = line_start ? '0 : hist_vld_q;
    base_cnt     = line_start ? '0 : cnt_q;
    old_vld      = base_vld[WINDOW-1];
    old_cls      = hist_cls_q[WINDOW-1];
    line_start_d = line_start_q;
    hist_vld_d   = hist_vld_q;
    hist_cls_d   = hist_cls_q;
    cnt_d        = cnt_q;
    if (accept) begin
      line_start_d = s_axi4s_tlast;
      for (int unsigned i = 1; i < WINDOW; i++) begin
        hist_vld_d[i] = base_vld[i-1];
        hist_cls_d[i] = hist_cls_q[i-1];
      end
      hist_vld_d[0] = new_vld;
      hist_cls_d[0] = new_cls;
      for (int unsigned c = 0; c < NUM_CLASS; c++) begin
        cnt_d[c] = base_cnt[c];
        if (new_vld && (new_cls == TNUMBER_WIDTH'(c)))
          cnt_d[c] = cnt_d[c] + TCOUNT_WIDTH'(1);
        if (old_vld && (old_cls == TNUMBER_WIDTH'(c)))
          cnt_d[c] = cnt_d[c] - TCOUNT_WIDTH'(1);
      end
    end
  end

  // Argmax of the post-update counters; strict compare keeps the lowest index on ties.
  always_comb begin
    win_num = '0;
    win_cnt = '0;
    for (int unsigned c = 0; c < NUM_CLASS; c++) begin
      if (cnt_d[c] > win_cnt) begin
        win_num = TNUMBER_WIDTH'(c);
        win_cnt = cnt_d[c];
      end
    end
  end

  // Single output register stage: load on accept, drop valid once consumed, hold on stall.
  always_comb begin
    m_tuser_d      = m_tuser_q;
    m_tlast_d      = m_tlast_q;
    m_tdata_d      = m_tdata_q;
    m_tbinary_d    = m_tbinary_q;
    m_tdetection_d = m_tdetection_q;
    m_tnumber_d    = m_tnumber_q;
    m_tcount_d     = m_tcount_q;
    m_tvalid_d     = m_tvalid_q;
    if (s_axi4s_tready) begin
      m_tvalid_d = s_axi4s_tvalid;
      if (accept) begin
        m_tuser_d      = s_axi4s_tuser;
        m_tlast_d      = s_axi4s_tlast;
        m_tdata_d      = s_axi4s_tdata;
        m_tbinary_d    = s_axi4s_tbinary;
        m_tdetection_d = s_axi4s_tdetection;
        m_tnumber_d    = win_num;
        m_tcount_d     = win_cnt;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_q   <= 1'b1;
      hist_vld_q     <= '0;
      hist_cls_q     <= '0;
      cnt_q          <= '0;
      m_tuser_q      <= '0;
      m_tlast_q      <= 1'b0;
      m_tdata_q      <= '0;
      m_tbinary_q    <= 1'b0;
      m_tdetection_q <= 1'b0;
      m_tnumber_q    <= '0;
      m_tcount_q     <= '0;
      m_tvalid_q     <= 1'b0;
    end else begin
      line_start_q   <= line_start_d;
      hist_vld_q     <= hist_vld_d;
      hist_cls_q     <= hist_cls_d;
      cnt_q          <= cnt_d;
      m_tuser_q      <= m_tuser_d;
      m_tlast_q      <= m_tlast_d;
      m_tdata_q      <= m_tdata_d;
      m_tbinary_q    <= m_tbinary_d;
      m_tdetection_q <= m_tdetection_d;
      m_tnumber_q    <= m_tnumber_d;
      m_tcount_q     <= m_tcount_d;
      m_tvalid_q     <= m_tvalid_d;
    end
  end

  assign m_axi4s_tuser      = m_tuser_q;
  assign m_axi4s_tlast      = m_tlast_q;
  assign m_axi4s_tdata      = m_tdata_q;
  assign m_axi4s_tbinary    = m_tbinary_q;
  assign m_axi4s_tdetection = m_tdetection_q;
  assign m_axi4s_tnumber    = m_tnumber_q;
  assign m_axi4s_tcount     = m_tcount_q;
  assign m_axi4s_tvalid     = m_tvalid_q;

endmodule

// File: tb/tb_video_mnist_seg_vote.sv
// Directed bench for video_mnist_seg_vote: window fill, ties, line/frame
// restarts, no-vote pixels, mid-line reset and a randomly stalled sink
// compared against a recount-based window model.
module tb_video_mnist_seg_vote;

  localparam int W = 8;
  localparam int N = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  s_tuser;
  logic        s_tlast;
  logic [23:0] s_tdata;
  logic [9:0]  s_tclass;
  logic        s_tbinary, s_tdetection, s_tvalid, s_tready;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic [23:0] m_tdata;
  logic        m_tbinary, m_tdetection;
  logic [3:0]  m_tnumber, m_tcount;
  logic        m_tvalid, m_tready;

  int checks = 0;
  int passes = 0;

  video_mnist_seg_vote #(
    .TUSER_WIDTH(1), .TDATA_WIDTH(24), .NUM_CLASS(10),
    .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(4), .WINDOW(W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tclass(s_tclass), .s_axi4s_tbinary(s_tbinary),
    .s_axi4s_tdetection(s_tdetection), .s_axi4s_tvalid(s_tvalid),
    .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
    .m_axi4s_tbinary(m_tbinary), .m_axi4s_tdetection(m_tdetection),
    .m_axi4s_tnumber(m_tnumber), .m_axi4s_tcount(m_tcount),
    .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present one beat with the sink always ready and check it one clock later.
  task automatic send(input string tag, input logic u, input logic l, input logic [9:0] cls,
                      input logic [23:0] d, input int en, input int ec);
    s_tuser = u; s_tlast = l; s_tclass = cls; s_tdata = d;
    s_tbinary = d[0]; s_tdetection = d[1]; s_tvalid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_vld"}, 64'(m_tvalid), 64'd1);
    chk({tag, "_num"}, 64'(m_tnumber), 64'(en));
    chk({tag, "_cnt"}, 64'(m_tcount), 64'(ec));
    chk({tag, "_side"}, {36'd0, m_tuser, m_tlast, m_tdata, m_tbinary, m_tdetection},
        {36'd0, u, l, d, d[0], d[1]});
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tuser = '0; s_tlast = 1'b0; s_tclass = '0;
    @(posedge clk); #1;
  endtask

  function automatic int lowbit(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Stall scenario stimulus and model results
  logic [9:0]  st_cls  [N];
  logic        st_user [N];
  logic        st_last [N];
  logic [23:0] st_data [N];
  int          ex_num  [N];
  int          ex_cnt  [N];
  int          hist    [10];

  int s2_num [12] = '{5, 5, 5, 5, 5, 5, 5, 2, 2, 2, 2, 2};
  int s2_cnt [12] = '{1, 2, 3, 4, 4, 4, 4, 4, 5, 6, 7, 8};

  int in_i, out_i, ls, lo, best, bc, k, r;
  logic        held;
  logic [63:0] held_val, cur_val;

  initial begin
    reset = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tuser = '0; s_tlast = 1'b0; s_tclass = '0;
    s_tdata = '0; s_tbinary = 1'b0; s_tdetection = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_sready", 64'(s_tready), 64'd1);
    chk("rst_out", {28'd0, m_tnumber, m_tcount, m_tdata}, 64'd0);
    reset = 1'b0;
    idle();

    // Fill a window with class 3, then saturate at WINDOW.
    for (int i = 0; i < 12; i++)
      send($sformatf("fill%0d", i), 1'b0, i == 11, 10'b1 << 3, 24'h100 + 24'(i),
           3, (i + 1 < W) ? i + 1 : W);

    // Class 5 then class 2: tie on pixel 7 resolves to the lower index.
    for (int i = 0; i < 12; i++)
      send($sformatf("tie%0d", i), 1'b0, i == 11, (i < 4) ? 10'b1 << 5 : 10'b1 << 2,
           24'h200 + 24'(i), s2_num[i], s2_cnt[i]);

    // Line boundary by tlast, then mid-line frame start by tuser.
    for (int i = 0; i < 6; i++)
      send($sformatf("la%0d", i), 1'b0, i == 5, 10'b1 << 4, 24'h300 + 24'(i), 4, i + 1);
    for (int i = 0; i < 3; i++)
      send($sformatf("lb%0d", i), 1'b0, 1'b0, 10'b1 << 7, 24'h310 + 24'(i), 7, i + 1);
    send("fs0", 1'b1, 1'b0, 10'b1 << 7, 24'h320, 7, 1);
    send("fs1", 1'b0, 1'b0, 10'b1 << 7, 24'h321, 7, 2);
    send("fs2", 1'b0, 1'b1, 10'b1 << 7, 24'h322, 7, 3);

    // No-vote pixels and multi-hot decode to the lowest set bit.
    for (int i = 0; i < 3; i++)
      send($sformatf("nv%0d", i), 1'b0, 1'b0, 10'b0, 24'h400 + 24'(i), 0, 0);
    send("mh0", 1'b0, 1'b0, 10'b0000010100, 24'h410, 2, 1);
    send("mh1", 1'b0, 1'b1, 10'b1000000100, 24'h411, 2, 2);

    // Reset pulsed mid-line discards the in-flight beat and history.
    for (int i = 0; i < 6; i++)
      send($sformatf("rl%0d", i), 1'b0, 1'b0, 10'b1 << 1, 24'h500 + 24'(i), 1, i + 1);
    reset = 1'b1; s_tclass = 10'b1 << 1; s_tdata = 24'h506; s_tvalid = 1'b1;
    @(posedge clk); #1;
    chk("mrst_vld", 64'(m_tvalid), 64'd0);
    chk("mrst_out", {56'd0, m_tnumber, m_tcount}, 64'd0);
    reset = 1'b0;
    send("mrst_p7", 1'b0, 1'b0, 10'b1 << 1, 24'h507, 1, 1);
    send("mrst_p8", 1'b0, 1'b1, 10'b1 << 1, 24'h508, 1, 2);
    idle();

    // Random stall scenario: build stimulus and recount-based expectations.
    for (int p = 0; p < N; p++) begin
      r = $urandom_range(0, 11);
      if (r == 10) st_cls[p] = '0;
      else if (r == 11) begin
        k = $urandom_range(0, 8);
        st_cls[p] = (10'b1 << k) | (10'b1 << $urandom_range(k + 1, 9));
      end else st_cls[p] = 10'b1 << r;
      st_user[p] = (p == 0) || ($urandom_range(0, 39) == 0);
      st_last[p] = ($urandom_range(0, 12) == 0);
      st_data[p] = 24'($urandom);
    end
    ls = 0;
    for (int p = 0; p < N; p++) begin
      if (p == 0 || st_user[p] || st_last[p-1]) ls = p;
      lo = (p - W + 1 > ls) ? p - W + 1 : ls;
      for (int c = 0; c < 10; c++) hist[c] = 0;
      for (int q = lo; q <= p; q++) begin
        k = lowbit(st_cls[q]);
        if (k >= 0) hist[k]++;
      end
      best = 0; bc = 0;
      for (int c = 0; c < 10; c++) if (hist[c] > bc) begin best = c; bc = hist[c]; end
      ex_num[p] = best; ex_cnt[p] = bc;
    end

    in_i = 0; out_i = 0; held = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 2000 && out_i < N; cyc++) begin
      m_tready = 1'($urandom_range(0, 1));
      s_tvalid = (in_i < N) && ($urandom_range(0, 3) != 0);
      if (in_i < N) begin
        s_tuser = st_user[in_i]; s_tlast = st_last[in_i]; s_tclass = st_cls[in_i];
        s_tdata = st_data[in_i]; s_tbinary = st_data[in_i][0]; s_tdetection = st_data[in_i][1];
      end
      @(negedge clk);
      chk("st_mvalid", 64'(m_tvalid), 64'(in_i != out_i));
      chk("st_sready", 64'(s_tready), 64'((in_i == out_i) || m_tready));
      cur_val = {28'd0, m_tuser, m_tlast, m_tdata, m_tbinary, m_tdetection, m_tnumber, m_tcount};
      if (held) chk("st_hold", cur_val, held_val);
      if (m_tvalid && out_i < N)
        chk($sformatf("st_out%0d", out_i), cur_val,
            {28'd0, st_user[out_i], st_last[out_i], st_data[out_i], st_data[out_i][0],
             st_data[out_i][1], 4'(ex_num[out_i]), 4'(ex_cnt[out_i])});
      held = m_tvalid && !m_tready;
      held_val = cur_val;
      if (m_tvalid && m_tready) out_i++;
      if (s_tvalid && s_tready) in_i++;
      @(posedge clk); #1;
    end
    chk("st_all_out", 64'(out_i), 64'(N));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
